// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back stage and its register file.
package wb_regfile_pkg;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_sel_t;
endpackage

// File: rtl/wb_regfile_wb_mux.sv
// Write-back value select, shared with the forwarding unit so both paths
// choose the same source for a given MemtoReg.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  wb_sel_t        sel_i,
  input  logic [W-1:0]   alu_i,
  input  logic [W-1:0]   mem_i,
  output logic [W-1:0]   data_o
);
  assign data_o = (sel_i == WB_MEM) ? mem_i : alu_i;
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the WB value, commits it to the register file,
// serves two read ports and counts retired writes. Optional macro: WB_BYPASS_EN.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CNT_W  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  RegWrite_i,
  input  logic                  MemtoReg_i,
  input  logic [DATA_W-1:0]     ALUResult_i,
  input  logic [DATA_W-1:0]     RDdata_i,
  input  logic [REG_IDX_W-1:0]  Instruction4_i,
  input  logic [REG_IDX_W-1:0]  RS1addr_i,
  input  logic [REG_IDX_W-1:0]  RS2addr_i,
  output logic [DATA_W-1:0]     RS1data_o,
  output logic [DATA_W-1:0]     RS2data_o,
  output logic [DATA_W-1:0]     WBdata_o,
  output logic                  WBen_o,
  output logic [CNT_W-1:0]      WrCount_o
);
  logic [DATA_W-1:0]    regs_q [NREG];
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [DATA_W-1:0]    wb_data;
  logic                 wb_en;
  wb_sel_t              wb_sel;
  logic [REG_IDX_W-1:0] raddr [2];
  logic [DATA_W-1:0]    rdata [2];

  assign wb_sel = MemtoReg_i ? WB_MEM : WB_ALU;

  wb_mux #(.W(DATA_W)) u_wb_mux (
    .sel_i  (wb_sel),
    .alu_i  (ALUResult_i),
    .mem_i  (RDdata_i),
    .data_o (wb_data)
  );

  // rst_i gates the enable so a write colliding with reset is never reported.
  assign wb_en = RegWrite_i & (Instruction4_i != REG_ZERO) & rst_i;

  always_comb begin
    cnt_d = cnt_q;
    if (wb_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      if (wb_en) begin
        regs_q[Instruction4_i] <= wb_data;
      end
      cnt_q <= cnt_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [REG_IDX_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (addr != REG_ZERO) begin
      val = regs_q[addr];
    end
`ifdef WB_BYPASS_EN
    // wb_en already excludes x0, so bypass can never make x0 non-zero.
    if (wb_en && (addr == Instruction4_i)) begin
      val = wb_data;
    end
`endif
    return val;
  endfunction

  assign raddr[0] = RS1addr_i;
  assign raddr[1] = RS2addr_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rport
    assign rdata[gi] = read_port(raddr[gi]);
  end

  assign RS1data_o = rdata[0];
  assign RS2data_o = rdata[1];
  assign WBdata_o  = wb_data;
  assign WBen_o    = wb_en;
  assign WrCount_o = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed, table-driven bench for wb_regfile with a 4-bit retired-write counter.
module tb_wb_regfile;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          regwrite;
  logic          memtoreg;
  logic [DW-1:0] alu;
  logic [DW-1:0] rddata;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [DW-1:0] rs1data;
  logic [DW-1:0] rs2data;
  logic [DW-1:0] wbdata;
  logic          wben;
  logic [CW-1:0] wrcount;

  int total = 0;
  int bad = 0;

  wb_regfile #(.DATA_W(DW), .NREG(32), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .RegWrite_i     (regwrite),
    .MemtoReg_i     (memtoreg),
    .ALUResult_i    (alu),
    .RDdata_i       (rddata),
    .Instruction4_i (rd),
    .RS1addr_i      (rs1),
    .RS2addr_i      (rs2),
    .RS1data_o      (rs1data),
    .RS2data_o      (rs2data),
    .WBdata_o       (wbdata),
    .WBen_o         (wben),
    .WrCount_o      (wrcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          rw;
    logic          m2r;
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [DW-1:0] e_wb;
    logic          e_en;
    logic [DW-1:0] e_rs1;
    logic [DW-1:0] e_rs2;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic m, input logic [DW-1:0] a,
                       input logic [DW-1:0] d, input logic [4:0] t, input logic [4:0] p1,
                       input logic [4:0] p2);
    @(negedge clk);
    rst = r; regwrite = w; memtoreg = m; alu = a; rddata = d; rd = t; rs1 = p1; rs2 = p2;
    #1;
  endtask

  initial begin
    // Values observed before the edge that commits this vector's inputs.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 4'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 5'd7, 5'd0, 5'd0, 32'hDEADBEEF, 1'b1, 32'h0, 32'h0, 4'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7, 32'h0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 4'd1};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h11, 32'hCAFEF00D, 5'd0, 5'd0, 5'd7, 32'hCAFEF00D, 1'b0, 32'h0, 32'hDEADBEEF, 4'd1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 4'd1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h1234, 32'h0, 5'd5, 5'd7, 5'd0, 32'h1234, 1'b1, 32'hDEADBEEF, 32'h0, 4'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7, 32'h0, 1'b0, 32'h1234, 32'hDEADBEEF, 4'd2};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7, 32'h0, 1'b0, 32'h0, 32'h0, 4'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'hBBBB, 32'hAAAA, 5'd9, 5'd5, 5'd7, 32'hAAAA, 1'b1, 32'h0, 32'h0, 4'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h99, 32'h0, 5'd9, 5'd9, 5'd9, 32'h99, 1'b0, 32'hAAAA, 32'hAAAA, 4'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 4'd0};

    rst = 1'b0; regwrite = 1'b0; memtoreg = 1'b0; alu = '0; rddata = '0;
    rd = '0; rs1 = '0; rs2 = '0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rst, vecs[i].rw, vecs[i].m2r, vecs[i].alu, vecs[i].mem,
            vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
      check($sformatf("v%0d.wbdata", i), wbdata, vecs[i].e_wb);
      check($sformatf("v%0d.wben", i), 32'(wben), 32'(vecs[i].e_en));
      check($sformatf("v%0d.rs1", i), rs1data, vecs[i].e_rs1);
      check($sformatf("v%0d.rs2", i), rs2data, vecs[i].e_rs2);
      check($sformatf("v%0d.cnt", i), 32'(wrcount), 32'(vecs[i].e_cnt));
      $display("vec %0d: rd=%0d wb=0x%08h en=%0b rs1=0x%08h rs2=0x%08h cnt=%0d",
               i, rd, wbdata, wben, rs1data, rs2data, wrcount);
    end

    // Same-cycle read of the write target on both ports.
    drive(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 5'd3, 5'd3, 5'd3);
`ifdef WB_BYPASS_EN
    check("same.rs1", rs1data, 32'h55);
    check("same.rs2", rs2data, 32'h55);
`else
    check("same.rs1", rs1data, 32'h0);
    check("same.rs2", rs2data, 32'h0);
`endif
    $display("same-cycle: rs1=0x%08h rs2=0x%08h", rs1data, rs2data);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    check("next.rs1", rs1data, 32'h55);
    check("next.rs2", rs2data, 32'h55);
    check("next.cnt", 32'(wrcount), 32'd1);
    $display("next-cycle: rs1=0x%08h rs2=0x%08h cnt=%0d", rs1data, rs2data, wrcount);

    // MemtoReg toggles before the edge: only the value present at the edge commits.
    drive(1'b1, 1'b1, 1'b1, 32'h77, 32'h66, 5'd4, 5'd0, 5'd0);
    check("tog.wb_mem", wbdata, 32'h66);
    #2 memtoreg = 1'b0;
    #1 check("tog.wb_alu", wbdata, 32'h77);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0);
    check("tog.x4", rs1data, 32'h77);
    check("tog.cnt", 32'(wrcount), 32'd2);
    $display("toggle: x4=0x%08h cnt=%0d", rs1data, wrcount);

    // Counter wrap: 13 more effective writes reach 15, the 14th wraps to 0.
    for (int k = 0; k < 13; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(k + 100), 32'h0, 5'(k + 10), 5'd0, 5'd0);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd22, 5'd10);
    check("wrap.cnt15", 32'(wrcount), 32'd15);
    check("wrap.x22", rs1data, 32'd112);
    check("wrap.x10", rs2data, 32'd100);
    $display("pre-wrap: cnt=%0d x22=%0d x10=%0d", wrcount, rs1data, rs2data);
    drive(1'b1, 1'b1, 1'b0, 32'hF00, 32'h0, 5'd31, 5'd0, 5'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd0);
    check("wrap.cnt0", 32'(wrcount), 32'd0);
    check("wrap.x31", rs1data, 32'hF00);
    $display("wrap: cnt=%0d x31=0x%08h", wrcount, rs1data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline interface: consumes the latched RegWrite, MemtoReg, ALUResult, RDdata and rd-index outputs of the MEM/WB register.
- Selects the write-back value and commits it to the 32x32 integer register file.
- Serves the two ID-stage read ports and exports the selected write-back value for EX forwarding.
- Keeps a retired-write counter for the bench and debug.

Parameters:
- DATA_W, 32, register and data width
- NREG, 32, number of architectural registers; index width is 5 bits and is fixed
- CNT_W, 32, width of the retired-write counter

Ports:
- clk_i  input  1  clock; all state updates on posedge
- rst_i  input  1  synchronous reset, active-low (0 = reset)
- RegWrite_i  input  1  write enable from the MEM/WB register
- MemtoReg_i  input  1  1 = write back RDdata_i, 0 = write back ALUResult_i
- ALUResult_i  input  DATA_W  ALU result from the MEM/WB register
- RDdata_i  input  DATA_W  memory load data from the MEM/WB register
- Instruction4_i  input  5  destination register index (instr[11:7])
- RS1addr_i  input  5  read port 1 index (instr[19:15])
- RS2addr_i  input  5  read port 2 index (instr[24:20])
- RS1data_o  output  DATA_W  read port 1 data
- RS2data_o  output  DATA_W  read port 2 data
- WBdata_o  output  DATA_W  selected write-back value, to the forwarding mux
- WBen_o  output  1  effective write this cycle: RegWrite_i and Instruction4_i != 0
- WrCount_o  output  CNT_W  number of effective writes since reset

Behaviour:
- WBdata_o is combinational: MemtoReg_i ? RDdata_i : ALUResult_i. The selection is valid regardless of RegWrite_i.
- WBen_o is combinational: RegWrite_i & (Instruction4_i != 0) & rst_i.
- At a posedge with rst_i = 0:
  - all NREG registers clear to 0
  - WrCount_o clears to 0
  - any concurrent write is discarded; reset wins over write.
- At a posedge with rst_i = 1 and WBen_o = 1:
  - reg[Instruction4_i] <= WBdata_o
  - WrCount_o <= WrCount_o + 1, wrapping from 2^CNT_W-1 to 0 with no flag.
- Writes to x0 are ignored and do not count. Reads of x0 always return 0, including under bypass.
- Read ports are combinational (zero latency). Without bypass, a write becomes visible to reads one cycle after its posedge.
- Both read ports may address the same register or the write target simultaneously; each port resolves independently.
- RegWrite_i = 1 with MemtoReg_i toggling: only the value present at the posedge is committed.
- Reset asserted mid-stream: the array clears at that edge. Read outputs after that edge are 0 until new writes occur.
- No stall/flush inputs: upstream injects bubbles as RegWrite_i = 0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: write-first internal bypass. When WBen_o = 1 and RSxaddr_i == Instruction4_i, RSxdata_o = WBdata_o in the same cycle. The ID stage therefore sees the value being written back with no extra forwarding path.
- Undefined: reads return only stored array contents. The hazard unit must stall one cycle or forward for WB-to-ID dependencies.

Decomposition:
- Shared package holds:
  - REG_IDX_W = 5
  - DATA_W = 32
  - REG_ZERO = 5'd0
  - the wb_sel_t enum (WB_ALU = 0, WB_MEM = 1)
- One sub-module, wb_mux: the combinational MemtoReg selection. It is reused by the forwarding unit so both paths select identically.
- Array, read ports, bypass and counter live in wb_regfile.

Test Plan:
- Reset: hold rst_i = 0 for 2 cycles after writing x5 = 0x1234 -> x5 reads 0 and WrCount_o = 0 afterwards.
- ALU path: RegWrite = 1, MemtoReg = 0, ALUResult = 0xDEADBEEF, rd = 7 -> WBdata_o = 0xDEADBEEF; RS1addr = 7 reads 0xDEADBEEF the next cycle; WrCount_o = 1.
- Load path plus x0: RegWrite = 1, MemtoReg = 1, RDdata = 0xCAFEF00D, rd = 0 -> WBen_o = 0; x0 reads 0; WrCount_o unchanged.
- Same-cycle read of the write target: rd = 3 = RS1addr = RS2addr, data 0x55 ->
  - with WB_BYPASS_EN, both ports show 0x55 that cycle;
  - without it, both ports show the old value 0 that cycle and 0x55 the next.
- Reset vs write collision: rst_i = 0 in the same cycle as a write of 0x99 to x9 -> x9 = 0 and WrCount_o = 0.
- Counter wrap: preload the counter via 2^CNT_W-1 writes (CNT_W = 4 in bench) -> the 16th effective write returns WrCount_o to 0.
